// File: rtl/div_arbiter.sv
// div_arbiter: two-way round-robin sequencer sharing one restoring divider.
// Latches a requester's operands on grant, walks the divider through its
// load/run handshake, and returns a tagged one-cycle result. A zero divisor
// is answered directly without touching the divider.
module div_arbiter #(
  parameter int n = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         req0,
  input  logic [n-1:0] a0,
  input  logic [n-1:0] b0,
  input  logic         req1,
  input  logic [n-1:0] a1,
  input  logic [n-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         rsp_vld,
  output logic         rsp_id,
  output logic [n-1:0] rsp_q,
  output logic [n-1:0] rsp_r,
  output logic         rsp_dz,
  output logic         div_s,
  output logic         div_LA,
  output logic         div_EB,
  output logic [n-1:0] div_DataA,
  output logic [n-1:0] div_DataB,
  input  logic         div_Done,
  input  logic [n-1:0] div_Q,
  input  logic [n-1:0] div_R
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_ptr;
  logic           r_id;
  logic [n-1:0]   r_a;
  logic [n-1:0]   r_b;
  logic [n-1:0]   r_rspQ;
  logic [n-1:0]   r_rspR;
  logic           r_rspDz;
  logic           r_rspId;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_grant;
  logic [n-1:0]   w_selA;
  logic [n-1:0]   w_selB;
  logic           w_selZero;

  // Choose a requester while idle; the pointer only matters when both ask
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == IDLE && resetn) begin
      if (req0 && (!req1 || !r_ptr)) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end
    end
  end

  assign w_grant   = w_gnt0 | w_gnt1;
  assign w_selA    = w_gnt1 ? a1 : a0;
  assign w_selB    = w_gnt1 ? b1 : b0;
  assign w_selZero = (w_selB == '0);

  // Next-state logic and the divider handshake strobes
  always_comb begin
    w_next  = r_state;
    div_s   = 1'b0;
    div_LA  = 1'b0;
    div_EB  = 1'b0;
    rsp_vld = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_next = w_selZero ? RESP : LOAD;
        end
      end
      LOAD: begin
        div_LA = 1'b1;
        div_EB = 1'b1;
        w_next = RUN;
      end
      RUN: begin
        div_s = 1'b1;
        if (div_Done) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_vld = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the granted operands and hand priority to the other requester
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_id  <= 1'b0;
      r_ptr <= 1'b0;
    end else if (w_grant) begin
      r_a   <= w_selA;
      r_b   <= w_selB;
      r_id  <= w_gnt1;
      r_ptr <= ~w_gnt1;
    end
  end

  // Result registers change only on entry to RESP and hold until the next one
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rspQ  <= '0;
      r_rspR  <= '0;
      r_rspDz <= 1'b0;
      r_rspId <= 1'b0;
    end else if (w_grant && w_selZero) begin
      r_rspQ  <= '1;
      r_rspR  <= w_selA;
      r_rspDz <= 1'b1;
      r_rspId <= w_gnt1;
    end else if (r_state == RUN && div_Done) begin
      r_rspQ  <= div_Q;
      r_rspR  <= div_R;
      r_rspDz <= 1'b0;
      r_rspId <= r_id;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign busy      = (r_state != IDLE) | w_grant;
  assign rsp_id    = r_rspId;
  assign rsp_q     = r_rspQ;
  assign rsp_r     = r_rspR;
  assign rsp_dz    = r_rspDz;
  assign div_DataA = r_a;
  assign div_DataB = r_b;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level
// model of the arbiter. The attached divider is a behavioural stand-in
// with selectable Done latency.
module tb_div_arbiter;

  localparam int N = 8;

  logic         clock;
  logic         resetn;
  logic         req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, rsp_vld, rsp_id, rsp_dz;
  logic [N-1:0] rsp_q, rsp_r;
  logic         div_s, div_LA, div_EB, div_Done;
  logic [N-1:0] div_DataA, div_DataB, div_Q, div_R;

  int checks = 0;
  int errors = 0;
  bit randLat = 0;

  div_arbiter #(.n(N)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz),
    .div_s(div_s), .div_LA(div_LA), .div_EB(div_EB),
    .div_DataA(div_DataA), .div_DataB(div_DataB),
    .div_Done(div_Done), .div_Q(div_Q), .div_R(div_R)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural divider: loads on LA/EB, raises Done after a latency while s
  // is high, holds Done until s drops
  logic [N-1:0] dA, dB;
  int dCnt, dLat;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_Done <= 1'b0; div_Q <= '0; div_R <= '0;
      dA <= '0; dB <= '0; dCnt <= 0; dLat <= 9;
    end else begin
      if (div_LA) begin
        dA   <= div_DataA;
        dLat <= randLat ? int'($urandom_range(1, 12)) : 9;
      end
      if (div_EB) dB <= div_DataB;
      if (!div_s) begin
        div_Done <= 1'b0;
        dCnt     <= 0;
      end else if (!div_Done) begin
        if (dCnt + 1 >= dLat) begin
          div_Done <= 1'b1;
          div_Q    <= (dB == 0) ? '1 : dA / dB;
          div_R    <= (dB == 0) ? dA : dA % dB;
        end else begin
          dCnt <= dCnt + 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one operation in flight, identified by its
  // age in cycles since grant; results are plain integer division
  bit           mBusy, mDz, mPtr, mId, mDoneSeen;
  int           mAge;
  logic [N-1:0] mA, mB, eQ, eR;
  bit           eDz, eId;
  always @(negedge clock) begin : compare
    bit eG0, eG1, eBusy, eVld, eS, eLA, eEB, chkData;
    eG0 = 0; eG1 = 0; eBusy = 0; eVld = 0; eS = 0; eLA = 0; eEB = 0; chkData = 0;
    if (!resetn) begin
      mBusy = 0; mPtr = 0; mA = '0; mB = '0;
      eQ = '0; eR = '0; eDz = 0; eId = 0;
      checkOutput("rstDataA", div_DataA, 0);
      checkOutput("rstDataB", div_DataB, 0);
    end else if (!mBusy) begin
      if (req0 && (!req1 || !mPtr)) begin
        eG0 = 1; mId = 0; mA = a0; mB = b0;
      end else if (req1) begin
        eG1 = 1; mId = 1; mA = a1; mB = b1;
      end
      if (eG0 || eG1) begin
        eBusy = 1; mBusy = 1; mPtr = !mId; mDz = (mB == 0);
        mAge = 0; mDoneSeen = 0;
      end
    end else begin
      mAge++;
      eBusy = 1;
      if (mDz) begin
        eVld = 1; eQ = '1; eR = mA; eDz = 1; eId = mId;
      end else if (mAge == 1) begin
        eLA = 1; eEB = 1; chkData = 1;
      end else if (mDoneSeen) begin
        eVld = 1; eQ = mA / mB; eR = mA % mB; eDz = 0; eId = mId;
      end else begin
        eS = 1; chkData = 1;
        if (div_Done) mDoneSeen = 1;
        if (mAge > 200) begin
          checks++; errors++;
          $display("[TB] FAIL doneTimeout: got no Done after %0d cycles, required one", mAge);
          mBusy = 0;
        end
      end
      if (eVld) mBusy = 0;
    end
    checkOutput("gnt0", gnt0, eG0);
    checkOutput("gnt1", gnt1, eG1);
    checkOutput("busy", busy, eBusy);
    checkOutput("rspVld", rsp_vld, eVld);
    checkOutput("rspId", rsp_id, eId);
    checkOutput("rspQ", rsp_q, eQ);
    checkOutput("rspR", rsp_r, eR);
    checkOutput("rspDz", rsp_dz, eDz);
    checkOutput("divS", div_s, eS);
    checkOutput("divLA", div_LA, eLA);
    checkOutput("divEB", div_EB, eEB);
    if (chkData) begin
      checkOutput("divDataA", div_DataA, mA);
      checkOutput("divDataB", div_DataB, mB);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    tick();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic waitGrant(output int id, output int waited);
    bit found;
    found = 0; id = -1; waited = 0;
    while (!found && waited < 60) begin
      @(negedge clock);
      waited++;
      if (gnt0 || gnt1) begin
        found = 1;
        id = gnt1 ? 1 : 0;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL grantTimeout: got no grant in %0d cycles, required one", waited);
    end
  endtask

  task automatic waitRsp(input string tag, input int id, input int q, input int r, input int dz);
    bit found;
    int waited;
    found = 0; waited = 0;
    while (!found && waited < 60) begin
      @(negedge clock);
      waited++;
      if (rsp_vld) found = 1;
    end
    if (!found) begin
      checks++; errors++;
      $display("[TB] FAIL %sTimeout: got no rsp_vld in %0d cycles, required one", tag, waited);
    end else begin
      checkOutput({tag, "Id"}, rsp_id, id);
      checkOutput({tag, "Q"}, rsp_q, q);
      checkOutput({tag, "R"}, rsp_r, r);
      checkOutput({tag, "Dz"}, rsp_dz, dz);
    end
  endtask

  // One random cycle of requester behaviour: hold until granted, then
  // optionally re-request with fresh operands; rare reset pulses
  task automatic applyStimulus();
    bit g0, g1;
    @(negedge clock);
    g0 = gnt0;
    g1 = gnt1;
    tick();
    if (!resetn) resetn = 1'b1;
    else if ($urandom_range(0, 599) == 0) resetn = 1'b0;
    if (req0 && g0) begin
      req0 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end else if (req0) begin
      if ($urandom_range(0, 29) == 0) req0 = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      req0 = 1'b1;
      a0 = 8'($urandom);
      b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end
    if (req1 && g1) begin
      req1 = 1'($urandom_range(0, 1));
      a1 = 8'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end else if (req1) begin
      if ($urandom_range(0, 29) == 0) req1 = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      req1 = 1'b1;
      a1 = 8'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end
  endtask

  // Directed scenarios followed by the randomized phase
  initial begin : mainFlow
    int id, waited;
    resetn = 1'b0;
    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    $display("[TB] basic 255/100 with operand change after grant");
    req0 = 1; a0 = 8'd255; b0 = 8'd100;
    @(negedge clock);
    checkOutput("t1Gnt0", gnt0, 1);
    checkOutput("t1Busy", busy, 1);
    tick();
    req0 = 0; a0 = 8'd3;
    @(negedge clock);
    checkOutput("t1LA", div_LA, 1);
    checkOutput("t1EB", div_EB, 1);
    repeat (10) @(negedge clock);
    checkOutput("t1EarlyVld", rsp_vld, 0);
    @(negedge clock);
    checkOutput("t1Vld", rsp_vld, 1);
    checkOutput("t1Id", rsp_id, 0);
    checkOutput("t1Q", rsp_q, 2);
    checkOutput("t1R", rsp_r, 55);
    checkOutput("t1Dz", rsp_dz, 0);

    $display("[TB] requester 1 alone 255/10");
    tick();
    req1 = 1; a1 = 8'd255; b1 = 8'd10;
    waitGrant(id, waited);
    checkOutput("t2Id", id, 1);
    tick();
    req1 = 0;
    waitRsp("t2", 1, 25, 5, 0);

    $display("[TB] simultaneous requests alternate");
    doReset();
    req0 = 1; a0 = 8'd200; b0 = 8'd7;
    req1 = 1; a1 = 8'd100; b1 = 8'd9;
    for (int k = 0; k < 4; k++) begin
      waitGrant(id, waited);
      checkOutput("t3Order", id, k % 2);
      checkOutput("t3Gap", waited, 1);
      if (k % 2 == 0) waitRsp("t3a", 0, 28, 4, 0);
      else            waitRsp("t3b", 1, 11, 1, 0);
    end
    tick();
    req0 = 0; req1 = 0;

    $display("[TB] divide by zero");
    doReset();
    req0 = 1; a0 = 8'd77; b0 = 8'd0;
    waitGrant(id, waited);
    checkOutput("t4Id", id, 0);
    tick();
    req0 = 0;
    @(negedge clock);
    checkOutput("t4Vld", rsp_vld, 1);
    checkOutput("t4Q", rsp_q, 255);
    checkOutput("t4R", rsp_r, 77);
    checkOutput("t4Dz", rsp_dz, 1);
    checkOutput("t4LA", div_LA, 0);
    tick();
    req0 = 1; a0 = 8'd10; b0 = 8'd3;
    req1 = 1; a1 = 8'd9;  b1 = 8'd2;
    waitGrant(id, waited);
    checkOutput("t4Tie", id, 1);
    tick();
    req1 = 0;
    waitRsp("t4b", 1, 4, 1, 0);
    waitGrant(id, waited);
    checkOutput("t4Next", id, 0);
    tick();
    req0 = 0;
    waitRsp("t4c", 0, 3, 1, 0);

    $display("[TB] reset during RUN");
    doReset();
    req0 = 1; a0 = 8'd255; b0 = 8'd100;
    waitGrant(id, waited);
    repeat (4) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    checkOutput("t5Busy", busy, 0);
    checkOutput("t5S", div_s, 0);
    checkOutput("t5Gnt0", gnt0, 0);
    checkOutput("t5Vld", rsp_vld, 0);
    tick();
    tick();
    resetn = 1'b1;
    waitGrant(id, waited);
    checkOutput("t5Regrant", id, 0);
    tick();
    req0 = 0;
    waitRsp("t5", 0, 2, 55, 0);

    $display("[TB] randomized traffic");
    randLat = 1;
    doReset();
    for (int c = 0; c < 4000; c++) applyStimulus();
    tick();
    resetn = 1'b1;
    req0 = 0; req1 = 0;
    repeat (40) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
